// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM loader bridge between data_io and the
// SDRAM loader port.
package rom_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } loader_entry_t;

  localparam int          ENTRY_W        = $bits(loader_entry_t);
  localparam logic [24:0] BASE_IDX0_DEF  = 25'h080000;
  localparam logic [24:0] BASE_OTHER_DEF = 25'h068000;

  // Image 0 is the OS/MOS ROM; everything else shares one region. Sum wraps mod 2^25.
  function automatic logic [24:0] map_addr(input logic [7:0]  idx,
                                           input logic [24:0] off,
                                           input logic [24:0] base_idx0,
                                           input logic [24:0] base_other);
    return ((idx == 8'd0) ? base_idx0 : base_other) + off;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_32m,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_32m) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap on their own.
  always_ff @(posedge clk_32m) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader_bridge.sv
// Buffers data_io download bytes, maps them into SDRAM ROM regions and issues
// one write per mem_sync slot; loader_active covers the full drain.
module rom_loader_bridge
  import rom_loader_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] BASE_IDX0  = BASE_IDX0_DEF,
  parameter logic [24:0] BASE_OTHER = BASE_OTHER_DEF
) (
  input  logic        clk_32m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        mem_sync,
  output logic        loader_active,
  output logic        loader_we,
  output logic [24:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        load_done,
  output logic        overflow,
  output logic [24:0] byte_count
);

  loader_state_t state, state_nxt;
  loader_entry_t push_ent, head_ent;

  logic       dl_q, dl_rise, dl_pend, start;
  logic [7:0] idx_q;
  logic       in_xfer, push_req;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign dl_rise   = ioctl_download && !dl_q;
  assign start     = (state == IDLE) && (dl_rise || dl_pend);
  assign in_xfer   = (state == LOAD) || (state == DRAIN);
  assign push_req  = (state == LOAD) && ioctl_wr;
  assign fifo_pop  = in_xfer && mem_sync && !fifo_empty;
  assign fifo_push = push_req && (!fifo_full || fifo_pop);

  assign push_ent.addr = map_addr(idx_q, ioctl_addr, BASE_IDX0, BASE_OTHER);
  assign push_ent.data = ioctl_dout;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_32m   (clk_32m),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_ent),
    .pop       (fifo_pop),
    .pop_data  (head_ent),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_32m) begin
    if (reset) begin
      state       <= IDLE;
      dl_q        <= 1'b0;
      dl_pend     <= 1'b0;
      idx_q       <= '0;
      loader_we   <= 1'b0;
      loader_addr <= '0;
      loader_data <= '0;
      overflow    <= 1'b0;
      byte_count  <= '0;
    end else begin
      state <= state_nxt;
      dl_q  <= ioctl_download;
      // Safe to latch on any rise: a draining load makes no more pushes.
      if (dl_rise) idx_q <= ioctl_index;

      if (start)                         dl_pend <= 1'b0;
      else if (dl_rise && state != IDLE) dl_pend <= 1'b1;

      if (in_xfer && mem_sync) begin
        loader_we <= !fifo_empty;
        if (!fifo_empty) begin
          loader_addr <= head_ent.addr;
          loader_data <= head_ent.data;
        end
      end else if (!in_xfer) begin
        loader_we <= 1'b0;
      end

      if (start) begin
        overflow   <= 1'b0;
        byte_count <= '0;
      end else if (push_req) begin
        if (fifo_push) begin
          if (byte_count != '1) byte_count <= byte_count + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // DRAIN ends once the FIFO is empty and the slot of the last write has closed.
  always_comb begin
    state_nxt     = state;
    loader_active = 1'b0;
    load_done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        loader_active = 1'b1;
        if (!ioctl_download) state_nxt = DRAIN;
      end
      DRAIN: begin
        loader_active = 1'b1;
        if (fifo_empty && (!loader_we || mem_sync)) state_nxt = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rom_loader_bridge.sv
// Directed bench for rom_loader_bridge: mapping, overflow, drain hold-off,
// pending restart, reset mid-load and full-FIFO push/pop.
module tb_rom_loader_bridge;

  logic        clk_32m = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        mem_sync = 1'b0;
  logic        loader_active, loader_we, load_done, overflow;
  logic [24:0] loader_addr, byte_count;
  logic [7:0]  loader_data;

  int tests = 0;
  int fails = 0;

  logic        ms_en = 1'b0;
  int          ms_per = 8;
  int          ms_cnt = 0;
  logic        ms_d = 1'b0;
  int          done_cnt = 0;
  logic [24:0] log_addr[$];
  logic [7:0]  log_data[$];

  rom_loader_bridge dut (
    .clk_32m        (clk_32m),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_sync       (mem_sync),
    .loader_active  (loader_active),
    .loader_we      (loader_we),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .load_done      (load_done),
    .overflow       (overflow),
    .byte_count     (byte_count)
  );

  initial forever #5 clk_32m = ~clk_32m;

  initial forever begin
    @(negedge clk_32m);
    if (ms_en) begin
      if (ms_cnt >= ms_per - 1) begin mem_sync = 1'b1; ms_cnt = 0; end
      else begin mem_sync = 1'b0; ms_cnt++; end
    end
  end

  // A write is logged in the cycle right after the mem_sync that issued it.
  always @(posedge clk_32m) ms_d <= mem_sync;
  always @(negedge clk_32m) begin
    if (ms_d && loader_we) begin
      log_addr.push_back(loader_addr);
      log_data.push_back(loader_data);
    end
    if (load_done) done_cnt++;
  end

  task automatic ms_start(input int per); ms_per = per; ms_en = 1'b1; endtask
  task automatic ms_stop(); ms_en = 1'b0; @(negedge clk_32m); mem_sync = 1'b0; endtask
  task automatic pulse_ms(); mem_sync = 1'b1; @(negedge clk_32m); mem_sync = 1'b0; endtask
  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1; @(negedge clk_32m);
  endtask
  task automatic end_dl(); ioctl_download = 1'b0; @(negedge clk_32m); endtask
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d; @(negedge clk_32m); ioctl_wr = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!load_done && n < 300) begin @(negedge clk_32m); n++; end
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL %s_timeout: load_done not seen in 300 cycles", name); end
  endtask

  task automatic test_reset();
    reset = 1'b1; repeat (3) @(negedge clk_32m);
    tests++; if ({loader_active, loader_we, load_done, overflow} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b exp 0000", {loader_active, loader_we, load_done, overflow}); end
    reset = 1'b0; @(negedge clk_32m);
    tests++; if ({loader_addr, loader_data} !== 33'd0) begin fails++; $display("FAIL reset_addr_data: got %h exp 0", {loader_addr, loader_data}); end
    tests++; if (byte_count !== 25'd0) begin fails++; $display("FAIL reset_count: got %0d exp 0", byte_count); end
    tests++; if (loader_active !== 1'b0) begin fails++; $display("FAIL reset_idle_active: got %b exp 0", loader_active); end
  endtask

  task automatic test_basic();
    logic [24:0] ea[3] = '{25'h080000, 25'h080001, 25'h080002};
    logic [7:0]  ed[3] = '{8'hA9, 8'h00, 8'h8D};
    int base, d0, n, gap;
    base = log_addr.size(); d0 = done_cnt; n = 0; gap = 0;
    ms_start(8);
    start_dl(8'd0);
    tests++; if (loader_active !== 1'b1) begin fails++; $display("FAIL basic_active_rise: got %b exp 1", loader_active); end
    for (int i = 0; i < 3; i++) wr_byte(25'(i), ed[i]);
    end_dl();
    while (!load_done && n < 300) begin
      if (!loader_active) gap++;
      @(negedge clk_32m); n++;
    end
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL basic_done_timeout: got %b exp 1", load_done); end
    tests++; if (loader_active !== 1'b0) begin fails++; $display("FAIL basic_active_at_done: got %b exp 0", loader_active); end
    tests++; if (gap != 0) begin fails++; $display("FAIL basic_active_gap: got %0d inactive cycles exp 0", gap); end
    repeat (2) @(negedge clk_32m);
    tests++; if (log_addr.size() - base != 3) begin fails++; $display("FAIL basic_nwrites: got %0d exp 3", log_addr.size() - base); end
    for (int i = 0; i < 3; i++) begin
      tests++; if ({log_addr[base+i], log_data[base+i]} !== {ea[i], ed[i]}) begin fails++; $display("FAIL basic_write%0d: got %h/%h exp %h/%h", i, log_addr[base+i], log_data[base+i], ea[i], ed[i]); end
    end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_pulses: got %0d exp 1", done_cnt - d0); end
    tests++; if (byte_count !== 25'd3) begin fails++; $display("FAIL basic_count: got %0d exp 3", byte_count); end
  endtask

  task automatic test_index1();
    int base;
    base = log_addr.size();
    start_dl(8'd1);
    wr_byte(25'h0000010, 8'h55);
    wr_byte(25'h1F98000, 8'hC3);
    end_dl();
    wait_done("index1");
    repeat (2) @(negedge clk_32m);
    tests++; if ({log_addr[base], log_data[base]} !== {25'h068010, 8'h55}) begin fails++; $display("FAIL index1_map: got %h/%h exp 068010/55", log_addr[base], log_data[base]); end
    tests++; if ({log_addr[base+1], log_data[base+1]} !== {25'h0000000, 8'hC3}) begin fails++; $display("FAIL index1_wrap: got %h/%h exp 0000000/c3", log_addr[base+1], log_data[base+1]); end
    tests++; if (byte_count !== 25'd2) begin fails++; $display("FAIL index1_count: got %0d exp 2", byte_count); end
  endtask

  task automatic test_overflow();
    int base;
    ms_stop();
    base = log_addr.size();
    start_dl(8'd0);
    for (int i = 0; i < 5; i++) wr_byte(25'(i), 8'h10 + 8'(i));
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b exp 1", overflow); end
    tests++; if (byte_count !== 25'd4) begin fails++; $display("FAIL ovf_count: got %0d exp 4", byte_count); end
    end_dl();
    ms_start(4);
    wait_done("ovf");
    repeat (2) @(negedge clk_32m);
    tests++; if (log_addr.size() - base != 4) begin fails++; $display("FAIL ovf_nwrites: got %0d exp 4", log_addr.size() - base); end
    for (int i = 0; i < 4; i++) begin
      tests++; if ({log_addr[base+i], log_data[base+i]} !== {25'h080000 + 25'(i), 8'h10 + 8'(i)}) begin fails++; $display("FAIL ovf_write%0d: got %h/%h exp %h/%h", i, log_addr[base+i], log_data[base+i], 25'h080000 + 25'(i), 8'h10 + 8'(i)); end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
    ms_stop();
    start_dl(8'd2);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
    tests++; if (byte_count !== 25'd0) begin fails++; $display("FAIL ovf_count_clear: got %0d exp 0", byte_count); end
    end_dl();
    wait_done("ovf_empty");
  endtask

  task automatic test_drain();
    ms_stop();
    start_dl(8'd0);
    wr_byte(25'h100, 8'hA1);
    wr_byte(25'h101, 8'hA2);
    end_dl();
    repeat (4) @(negedge clk_32m);
    tests++; if ({loader_active, load_done} !== 2'b10) begin fails++; $display("FAIL drain_hold: got %b exp 10", {loader_active, load_done}); end
    pulse_ms();
    tests++; if ({loader_we, loader_addr, loader_data} !== {1'b1, 25'h080100, 8'hA1}) begin fails++; $display("FAIL drain_slot1: got %b/%h/%h exp 1/080100/a1", loader_we, loader_addr, loader_data); end
    repeat (3) @(negedge clk_32m);
    tests++; if ({loader_we, loader_addr} !== {1'b1, 25'h080100}) begin fails++; $display("FAIL drain_slot1_hold: got %b/%h exp 1/080100", loader_we, loader_addr); end
    pulse_ms();
    tests++; if ({loader_we, loader_addr, loader_data} !== {1'b1, 25'h080101, 8'hA2}) begin fails++; $display("FAIL drain_slot2: got %b/%h/%h exp 1/080101/a2", loader_we, loader_addr, loader_data); end
    @(negedge clk_32m);
    tests++; if ({loader_active, load_done} !== 2'b10) begin fails++; $display("FAIL drain_slot_end_wait: got %b exp 10", {loader_active, load_done}); end
    pulse_ms();
    tests++; if ({loader_active, load_done, loader_we} !== 3'b010) begin fails++; $display("FAIL drain_done: got %b exp 010", {loader_active, load_done, loader_we}); end
    @(negedge clk_32m);
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL drain_done_once: got %b exp 0", load_done); end
  endtask

  task automatic test_pending();
    start_dl(8'd0);
    wr_byte(25'h5, 8'h77);
    end_dl();
    @(negedge clk_32m);
    start_dl(8'd1);
    tests++; if ({loader_active, byte_count} !== {1'b1, 25'd1}) begin fails++; $display("FAIL pend_held: got %b/%0d exp 1/1", loader_active, byte_count); end
    pulse_ms();
    pulse_ms();
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL pend_done: got %b exp 1", load_done); end
    @(negedge clk_32m);
    @(negedge clk_32m);
    tests++; if ({loader_active, byte_count} !== {1'b1, 25'd0}) begin fails++; $display("FAIL pend_restart: got %b/%0d exp 1/0", loader_active, byte_count); end
    wr_byte(25'h0, 8'h99);
    end_dl();
    pulse_ms();
    tests++; if ({loader_addr, loader_data} !== {25'h068000, 8'h99}) begin fails++; $display("FAIL pend_index: got %h/%h exp 068000/99", loader_addr, loader_data); end
    pulse_ms();
    @(negedge clk_32m);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) wr_byte(25'(i), 8'hE0 + 8'(i));
    reset = 1'b1; ioctl_download = 1'b0;
    @(negedge clk_32m);
    tests++; if ({loader_active, loader_we, load_done, overflow, loader_addr, loader_data} !== 37'd0) begin fails++; $display("FAIL rstmid_outputs: got %b%b%b%b/%h/%h exp all 0", loader_active, loader_we, load_done, overflow, loader_addr, loader_data); end
    tests++; if (byte_count !== 25'd0) begin fails++; $display("FAIL rstmid_count: got %0d exp 0", byte_count); end
    reset = 1'b0;
    ms_start(2);
    repeat (30) begin @(negedge clk_32m); if (loader_we || loader_active) bad++; end
    tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_no_write: got %0d active cycles exp 0", bad); end
    ms_stop();
  endtask

  task automatic test_back_to_back();
    int base;
    base = log_addr.size();
    start_dl(8'd0);
    for (int i = 0; i < 4; i++) wr_byte(25'h20 + 25'(i), 8'hB0 + 8'(i));
    ioctl_wr = 1'b1; ioctl_addr = 25'h24; ioctl_dout = 8'hB4; mem_sync = 1'b1;
    @(negedge clk_32m);
    ioctl_wr = 1'b0; mem_sync = 1'b0;
    tests++; if ({loader_we, loader_addr, loader_data} !== {1'b1, 25'h080020, 8'hB0}) begin fails++; $display("FAIL b2b_head: got %b/%h/%h exp 1/080020/b0", loader_we, loader_addr, loader_data); end
    tests++; if ({overflow, byte_count} !== {1'b0, 25'd5}) begin fails++; $display("FAIL b2b_accept: got %b/%0d exp 0/5", overflow, byte_count); end
    end_dl();
    ms_start(3);
    wait_done("b2b");
    repeat (2) @(negedge clk_32m);
    tests++; if (log_addr.size() - base != 5) begin fails++; $display("FAIL b2b_nwrites: got %0d exp 5", log_addr.size() - base); end
    tests++; if ({log_addr[base+4], log_data[base+4]} !== {25'h080024, 8'hB4}) begin fails++; $display("FAIL b2b_last: got %h/%h exp 080024/b4", log_addr[base+4], log_data[base+4]); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_no_ovf: got %b exp 0", overflow); end
  endtask

  initial begin
    @(negedge clk_32m);
    test_reset();
    test_basic();
    test_index1();
    test_overflow();
    test_drain();
    test_pending();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_loader_bridge.md
Name: rom_loader_bridge

Overview:
- Sits between data_io (SPI ROM/image download) and the SDRAM controller's loader port.
- Buffers ioctl bytes in a small FIFO and maps each byte to its SDRAM ROM region by ioctl_index.
- Issues one write per mem_sync memory slot.
- Holds loader_active until the last buffered byte has been committed, so core reset is not released early.

Parameters:
- FIFO_DEPTH, 4, entry count; power of two, ≥2.
- BASE_IDX0, 25'h080000, SDRAM base for ioctl_index==0 (OS/MOS ROM image).
- BASE_OTHER, 25'h068000, SDRAM base for any other ioctl_index.

Ports:
- clk_32m  in  1  system clock
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download in progress (from data_io)
- ioctl_index  in  8  image index; sampled on download rising edge
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte offset within image
- ioctl_dout  in  8  byte data
- mem_sync  in  1  one-cycle memory slot strobe from core
- loader_active  out  1  drives SDRAM mux select and core reset
- loader_we  out  1  SDRAM write enable, valid for one slot
- loader_addr  out  25  SDRAM byte address
- loader_data  out  8  SDRAM write data
- load_done  out  1  one-cycle pulse when a load fully completes
- overflow  out  1  sticky: a byte was dropped
- byte_count  out  25  bytes accepted in current/last load

Behaviour:
- Reset values:
  - Outputs: loader_active=0, loader_we=0, loader_addr=0, loader_data=0, load_done=0, overflow=0, byte_count=0.
  - Internal: FIFO empty, state IDLE.
- Reset mid-load: buffered bytes are discarded and the FSM returns to IDLE; no further writes issue.
- Address mapping: base = (latched index==0) ? BASE_IDX0 : BASE_OTHER.
  - Entry address = base + ioctl_addr, modulo 2^25; overflow of the sum wraps silently.
  - Computed at push time; the FIFO stores the {addr,data} pair.
- Index latch: on the ioctl_download 0→1 edge, ioctl_index is latched, overflow is cleared and byte_count is cleared.
- FSM states:
  - IDLE→LOAD on ioctl_download rising edge; loader_active=1 from the next cycle.
  - LOAD: push on ioctl_wr. LOAD→DRAIN when ioctl_download falls.
  - DRAIN: accepts no pushes. When the FIFO is empty and the last issued write's slot has ended (next mem_sync after it), go to DONE.
  - DONE: load_done=1 for exactly one cycle; loader_active=0; return to IDLE.
  - A new download rising edge in DRAIN is held off: it is recognised only once the FSM reaches IDLE, and the edge detector keeps a pending flag.
- Push:
  - ioctl_wr is honoured only in LOAD.
  - When the FIFO is not full: enqueue and increment byte_count.
  - When full and no pop happens that same cycle: drop the byte and set overflow (sticky).
  - Push and pop in the same cycle on a full FIFO: both succeed and the count is unchanged.
- Pop/issue, on each mem_sync cycle while in LOAD or DRAIN:
  - FIFO non-empty: pop the head, register it to loader_addr/loader_data, set loader_we=1.
  - FIFO empty: loader_we=0.
  - loader_we, loader_addr and loader_data hold until the next mem_sync, giving one full slot per write.
  - loader_we is forced 0 in IDLE and DONE.
- Latency: a byte pushed with the FIFO empty appears on loader_* at the first mem_sync strictly after the push cycle.
- ioctl_wr during IDLE/DRAIN/DONE: ignored, no overflow.
- byte_count saturates at 2^25-1.

Decomposition:
- Shared package rom_loader_pkg:
  - typedef loader_state_t {IDLE, LOAD, DRAIN, DONE}
  - typedef loader_entry_t {addr[24:0], data[7:0]}
  - Base-address constants
- Sub-module sync_fifo: single-clock, parameterised width/depth, with push, pop, full, empty and simultaneous push/pop support. Instantiated once with loader_entry_t width 33.

Test Plan:
- Index 0, download of 3 bytes {0xA9,0x00,0x8D} at addr 0..2, mem_sync every 8 cycles → three slot writes to 0x080000/1/2 in order, byte_count=3, load_done pulses once, loader_active falls after the third slot.
- Index 1, addr 0x00010, data 0x55 → loader_addr=0x068010.
- Five ioctl_wr back-to-back with mem_sync idle (DEPTH=4) → four bytes written, fifth dropped, overflow=1. The next download start clears overflow and byte_count.
- Download ends with 2 bytes buffered → loader_active stays 1 through 2 more slots plus the slot end, then drops; load_done is asserted the cycle loader_active drops.
- Assert reset while 3 bytes are buffered → all outputs return to reset values next cycle and no loader_we pulse follows.
- ioctl_wr coincident with mem_sync on a full FIFO → head issued, new byte accepted, overflow stays 0.
